// File: rtl/video_pll_lock_supervisor.sv
// Video PLL lock supervisor: sequences the PLL reset, qualifies lock and releases sys_rst.
// Optional retry limit with a sticky FAIL state when VIDEO_PLL_SUP_RETRY_LIMIT_EN is defined.
module video_pll_lock_supervisor #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned PLL_RST_CYCLES = 16,
    parameter int unsigned LOCK_TIMEOUT   = 100000,
    parameter int unsigned STABLE_CYCLES  = 1024,
`ifdef VIDEO_PLL_SUP_RETRY_LIMIT_EN
    parameter int unsigned MAX_RETRIES    = 8,
`endif
    parameter int unsigned CNT_W          = 8
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             locked,
    output logic             pll_rst,
    output logic             sys_rst,
    output logic             ready,
    output logic [CNT_W-1:0] loss_count,
    output logic [CNT_W-1:0] timeout_count,
    output logic             fail
);

    localparam int unsigned MaxAb = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES
                                                                     : LOCK_TIMEOUT;
    localparam int unsigned MaxCycles = (MaxAb > STABLE_CYCLES) ? MaxAb : STABLE_CYCLES;
    localparam int unsigned TW = $clog2(MaxCycles + 1);

    localparam logic [TW-1:0] RstLast     = TW'(PLL_RST_CYCLES - 1);
    localparam logic [TW-1:0] TimeoutLast = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] StableLast  = TW'(STABLE_CYCLES - 1);

    typedef enum logic [2:0] {
        StResetPll,
        StWaitLock,
        StStable,
        StRun
`ifdef VIDEO_PLL_SUP_RETRY_LIMIT_EN
        , StFail
`endif
    } state_e;

    state_e                 state_q, state_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   locked_s;
    logic                   timeout_hit;
    logic                   loss_hit;

    assign locked_s = sync_q[SYNC_STAGES-1];

`ifdef VIDEO_PLL_SUP_RETRY_LIMIT_EN
    localparam int unsigned RW = $clog2(MAX_RETRIES + 1);
    localparam logic [RW-1:0] RetryLast = RW'(MAX_RETRIES - 1);
    logic [RW-1:0] retry_q;
`endif

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q + 1'b1;
        timeout_hit = 1'b0;
        loss_hit    = 1'b0;
        case (state_q)
            StResetPll: if (timer_q == RstLast) state_d = StWaitLock;
            StWaitLock: begin
                // Lock takes priority over a coincident timeout.
                if (locked_s) begin
                    state_d = StStable;
                end else if (timer_q == TimeoutLast) begin
                    timeout_hit = 1'b1;
`ifdef VIDEO_PLL_SUP_RETRY_LIMIT_EN
                    state_d = (retry_q == RetryLast) ? StFail : StResetPll;
`else
                    state_d = StResetPll;
`endif
                end
            end
            StStable: begin
                if (!locked_s) begin
                    state_d = StWaitLock;
                end else if (timer_q == StableLast) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                timer_d = timer_q;
                if (!locked_s) begin
                    state_d  = StResetPll;
                    loss_hit = 1'b1;
                end
            end
`ifdef VIDEO_PLL_SUP_RETRY_LIMIT_EN
            StFail: timer_d = timer_q;
`endif
            default: state_d = StResetPll;
        endcase
        if (state_d != state_q) timer_d = '0;
    end

    // Outputs are decoded from state_d so they move on the same edge as the state.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q       <= StResetPll;
            timer_q       <= '0;
            sync_q        <= '0;
            pll_rst       <= 1'b1;
            sys_rst       <= 1'b1;
            ready         <= 1'b0;
            loss_count    <= '0;
            timeout_count <= '0;
`ifdef VIDEO_PLL_SUP_RETRY_LIMIT_EN
            fail          <= 1'b0;
            retry_q       <= '0;
`endif
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], locked};
            state_q <= state_d;
            timer_q <= timer_d;
            sys_rst <= (state_d != StRun);
            ready   <= (state_d == StRun);
`ifdef VIDEO_PLL_SUP_RETRY_LIMIT_EN
            pll_rst <= (state_d == StResetPll) || (state_d == StFail);
            fail    <= (state_d == StFail);
            if (state_d == StRun) begin
                retry_q <= '0;
            end else if (timeout_hit) begin
                retry_q <= retry_q + 1'b1;
            end
`else
            pll_rst <= (state_d == StResetPll);
`endif
            if (timeout_hit && (timeout_count != '1)) timeout_count <= timeout_count + 1'b1;
            if (loss_hit && (loss_count != '1)) loss_count <= loss_count + 1'b1;
        end
    end

`ifndef VIDEO_PLL_SUP_RETRY_LIMIT_EN
    assign fail = 1'b0;
`endif

endmodule

// File: tb/tb_video_pll_lock_supervisor.sv
// Directed bench for video_pll_lock_supervisor: instance a uses default timing,
// instance b a short configuration (STABLE_CYCLES=8, LOCK_TIMEOUT=50, CNT_W=2).
module tb_video_pll_lock_supervisor;

    logic       clk = 1'b0;
    logic       rst_a, locked_a, pll_rst_a, sys_rst_a, ready_a, fail_a;
    logic [7:0] loss_a, tout_a;
    logic       rst_b, locked_b, pll_rst_b, sys_rst_b, ready_b, fail_b;
    logic [1:0] loss_b, tout_b;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    video_pll_lock_supervisor dut_a (
        .refclk        (clk),
        .rst           (rst_a),
        .locked        (locked_a),
        .pll_rst       (pll_rst_a),
        .sys_rst       (sys_rst_a),
        .ready         (ready_a),
        .loss_count    (loss_a),
        .timeout_count (tout_a),
        .fail          (fail_a)
    );

    video_pll_lock_supervisor #(
        .STABLE_CYCLES (8),
        .LOCK_TIMEOUT  (50),
`ifdef VIDEO_PLL_SUP_RETRY_LIMIT_EN
        .MAX_RETRIES   (3),
`endif
        .CNT_W         (2)
    ) dut_b (
        .refclk        (clk),
        .rst           (rst_b),
        .locked        (locked_b),
        .pll_rst       (pll_rst_b),
        .sys_rst       (sys_rst_b),
        .ready         (ready_b),
        .loss_count    (loss_b),
        .timeout_count (tout_b),
        .fail          (fail_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after an edge; outputs are sampled there too.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  cnt;
        logic sys_ok;
        rst_a = 1'b1; rst_b = 1'b1; locked_a = 1'b0; locked_b = 1'b0;
        tick(3);
        check_eq("rst_pll_rst", pll_rst_a, 1);
        check_eq("rst_sys_rst", sys_rst_a, 1);
        check_eq("rst_ready", ready_a, 0);
        check_eq("rst_fail", fail_a, 0);
        check_eq("rst_loss", loss_a, 0);
        check_eq("rst_tout", tout_a, 0);

        // 1: pll_rst held for PLL_RST_CYCLES after release, sys_rst held throughout
        rst_a = 1'b0;
        cnt = 0;
        sys_ok = 1'b1;
        while (pll_rst_a && cnt < 100) begin
            cnt++;
            if (!sys_rst_a || ready_a) sys_ok = 1'b0;
            tick(1);
        end
        check_eq("t1_pll_rst_len", cnt, 16);
        check_eq("t1_sys_held", sys_ok, 1);
        tick(5);
        check_eq("t1_pll_rst_low", pll_rst_a, 0);
        check_eq("t1_sys_rst_wait", sys_rst_a, 1);

        // 2: lock 2 sync edges + 1 FSM edge to STABLE, then 1024 stable cycles
        locked_a = 1'b1;
        tick(1026);
        check_eq("t2_sys_rst_before", sys_rst_a, 1);
        tick(1);
        check_eq("t2_sys_rst_release", sys_rst_a, 0);
        check_eq("t2_ready", ready_a, 1);
        check_eq("t2_loss", loss_a, 0);
        check_eq("t2_tout", tout_a, 0);

        // 3: glitch during STABLE returns to WAIT_LOCK and restarts qualification
        tick(1);
        rst_b = 1'b0;
        tick(16);
        check_eq("t3_pll_rst_low", pll_rst_b, 0);
        locked_b = 1'b1;
        tick(3 + 4);
        locked_b = 1'b0;
        tick(3);
        locked_b = 1'b1;
        check_eq("t3_no_run_glitch", sys_rst_b, 1);
        tick(10);
        check_eq("t3_sys_rst_before", sys_rst_b, 1);
        tick(1);
        check_eq("t3_sys_rst_release", sys_rst_b, 0);
        check_eq("t3_ready", ready_b, 1);
        check_eq("t3_loss", loss_b, 0);
        check_eq("t3_tout", tout_b, 0);

        // 4: lock loss in RUN: reaction on the third edge after the drop
        locked_b = 1'b0;
        tick(2);
        check_eq("t4_still_run", sys_rst_b, 0);
        tick(1);
        check_eq("t4_sys_rst", sys_rst_b, 1);
        check_eq("t4_pll_rst", pll_rst_b, 1);
        check_eq("t4_ready", ready_b, 0);
        check_eq("t4_loss", loss_b, 1);
        tick(1);
        locked_b = 1'b1;
        tick(14);
        check_eq("t4_pll_rst_hold", pll_rst_b, 1);
        tick(1);
        check_eq("t4_pll_rst_fall", pll_rst_b, 0);
        tick(8);
        check_eq("t4_sys_rst_before", sys_rst_b, 1);
        tick(1);
        check_eq("t4_rerun", sys_rst_b, 0);
        check_eq("t4_loss_kept", loss_b, 1);
        check_eq("t4_tout", tout_b, 0);

        // 5: no lock: pll_rst pulses every 16+50 cycles, 2-bit count saturates at 3
        rst_b = 1'b1;
        locked_b = 1'b0;
        tick(2);
        check_eq("t5_rst_loss", loss_b, 0);
        rst_b = 1'b0;
        tick(65);
        check_eq("t5_wait_1", pll_rst_b, 0);
        check_eq("t5_tout_0", tout_b, 0);
        tick(1);
        check_eq("t5_pulse_1", pll_rst_b, 1);
        check_eq("t5_tout_1", tout_b, 1);
`ifdef VIDEO_PLL_SUP_RETRY_LIMIT_EN
        for (int n = 2; n <= 3; n++) begin
`else
        for (int n = 2; n <= 5; n++) begin
`endif
            tick(65);
            check_eq("t5_wait_n", pll_rst_b, 0);
            tick(1);
            check_eq("t5_pulse_n", pll_rst_b, 1);
            check_eq("t5_tout_n", tout_b, (n > 3) ? 3 : n);
        end

`ifdef VIDEO_PLL_SUP_RETRY_LIMIT_EN
        // 6: third consecutive timeout is terminal until rst
        check_eq("t6_fail", fail_b, 1);
        tick(100);
        check_eq("t6_fail_sticky", fail_b, 1);
        check_eq("t6_pll_rst_stuck", pll_rst_b, 1);
        check_eq("t6_sys_rst", sys_rst_b, 1);
        rst_b = 1'b1;
        tick(1);
        rst_b = 1'b0;
        check_eq("t6_fail_cleared", fail_b, 0);
        check_eq("t6_pll_rst", pll_rst_b, 1);
        tick(16);
        check_eq("t6_resequence", pll_rst_b, 0);
`else
        check_eq("t5_fail_tied", fail_b, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
